// File: rtl/encoder_8x3_pkg.sv
// Shared widths, index type and constants for the 8-to-3 encoder.
package enc_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 3;

    typedef logic [OUT_W-1:0] enc_idx_t;

    localparam enc_idx_t ENC_IDX_ZERO = 3'b000;

endpackage : enc_pkg

// File: rtl/encoder_8x3_onehot_check.sv
// Combinational classifier: flags zero/multi-hot vectors and yields the highest set-bit index.
module onehot_check
    import enc_pkg::*;
(
    input  logic [IN_W-1:0] vec,
    output logic            is_zero,
    output logic            is_multi,
    output enc_idx_t        high_idx
);

    // Zero and multi-hot detection; clearing the lowest set bit leaves something only if 2+ bits were set.
    always_comb begin
        is_zero  = (vec == 8'h00);
        is_multi = ((vec & (vec - 8'd1)) != 8'h00);
    end

    // Highest-set-bit priority index; zero input maps to index 0.
    always_comb begin
        high_idx = ENC_IDX_ZERO;
        casez (vec)
            8'b1???????: high_idx = 3'd7;
            8'b01??????: high_idx = 3'd6;
            8'b001?????: high_idx = 3'd5;
            8'b0001????: high_idx = 3'd4;
            8'b00001???: high_idx = 3'd3;
            8'b000001??: high_idx = 3'd2;
            8'b0000001?: high_idx = 3'd1;
            8'b00000001: high_idx = 3'd0;
            default:     high_idx = ENC_IDX_ZERO;
        endcase
    end

endmodule : onehot_check

// File: rtl/encoder_8x3.sv
// Registered 8-to-3 encoder with zero/multi-hot flags and a saturating error counter.
module encoder_8x3
    import enc_pkg::*;
#(
    parameter int PRIORITY_MODE = 0,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    input  logic             clr_count,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic             err_none,
    output logic             err_multi,
    output logic [CNT_W-1:0] err_count
);

    localparam logic             STRICT  = (PRIORITY_MODE == 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic     is_zero_s;
    logic     is_multi_s;
    enc_idx_t high_idx_s;
    logic     is_err_s;

    enc_idx_t         out_d, out_q;
    logic             valid_d, valid_q;
    logic             err_none_d, err_none_q;
    logic             err_multi_d, err_multi_q;
    logic [CNT_W-1:0] err_count_d, err_count_q;

    onehot_check u_onehot_check (
        .vec      (in),
        .is_zero  (is_zero_s),
        .is_multi (is_multi_s),
        .high_idx (high_idx_s)
    );

    // Multi-hot only counts as an error when priority encoding is disabled.
    assign is_err_s = is_zero_s | (is_multi_s & STRICT);

    // Next-state for the encoded outputs; everything holds while en is low.
    always_comb begin
        out_d       = out_q;
        valid_d     = valid_q;
        err_none_d  = err_none_q;
        err_multi_d = err_multi_q;
        if (en) begin
            err_none_d  = is_zero_s;
            err_multi_d = is_multi_s;
            if (is_err_s) begin
                out_d   = ENC_IDX_ZERO;
                valid_d = 1'b0;
            end else begin
                out_d   = high_idx_s;
                valid_d = 1'b1;
            end
        end else begin
            out_d       = out_q;
            valid_d     = valid_q;
            err_none_d  = err_none_q;
            err_multi_d = err_multi_q;
        end
    end

    // Error counter: clear wins over increment and ignores en; saturates at all-ones.
    always_comb begin
        err_count_d = err_count_q;
        if (clr_count) begin
            err_count_d = {CNT_W{1'b0}};
        end else if (en && is_err_s && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= ENC_IDX_ZERO;
            valid_q     <= 1'b0;
            err_none_q  <= 1'b0;
            err_multi_q <= 1'b0;
            err_count_q <= {CNT_W{1'b0}};
        end else begin
            out_q       <= out_d;
            valid_q     <= valid_d;
            err_none_q  <= err_none_d;
            err_multi_q <= err_multi_d;
            err_count_q <= err_count_d;
        end
    end

    assign out       = out_q;
    assign valid     = valid_q;
    assign err_none  = err_none_q;
    assign err_multi = err_multi_q;
    assign err_count = err_count_q;

endmodule : encoder_8x3

// File: tb/tb_encoder_8x3.sv
// Self-checking bench: three encoder variants (strict, priority, 2-bit counter) on shared stimulus.
module tb_encoder_8x3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] in_s;
    logic       clr_count;

    logic [2:0] out_w   [3];
    logic       valid_w [3];
    logic       none_w  [3];
    logic       multi_w [3];
    logic [7:0] cnt0_w, cnt1_w;
    logic [1:0] cnt2_w;

    int pm [3] = '{0, 1, 0};
    int cw [3] = '{8, 8, 2};

    int m_out [3];
    int m_valid [3];
    int m_none [3];
    int m_multi [3];
    int m_cnt [3];

    int n_total;
    int n_pass;

    typedef struct {
        logic [7:0] vin;
        int         exp_out;
        int         exp_valid;
        int         exp_none;
        int         exp_multi;
    } vec_t;

    vec_t tbl [11];

    encoder_8x3 #(.PRIORITY_MODE(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .en(en), .in(in_s), .clr_count(clr_count),
        .out(out_w[0]), .valid(valid_w[0]), .err_none(none_w[0]),
        .err_multi(multi_w[0]), .err_count(cnt0_w)
    );
    encoder_8x3 #(.PRIORITY_MODE(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in(in_s), .clr_count(clr_count),
        .out(out_w[1]), .valid(valid_w[1]), .err_none(none_w[1]),
        .err_multi(multi_w[1]), .err_count(cnt1_w)
    );
    encoder_8x3 #(.PRIORITY_MODE(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .in(in_s), .clr_count(clr_count),
        .out(out_w[2]), .valid(valid_w[2]), .err_none(none_w[2]),
        .err_multi(multi_w[2]), .err_count(cnt2_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cnt_of(input int k);
        if (k == 0) return int'(cnt0_w);
        else if (k == 1) return int'(cnt1_w);
        else return int'(cnt2_w);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_out[k] = 0; m_valid[k] = 0; m_none[k] = 0; m_multi[k] = 0; m_cnt[k] = 0;
        end
    endtask

    // Reference: popcount + highest set bit, rules applied straight from the behaviour description.
    task automatic model_update();
        int pc;
        int hi;
        bit is_err;
        pc = $countones(in_s);
        hi = 0;
        for (int b = 0; b < 8; b++) if (in_s[b]) hi = b;
        for (int k = 0; k < 3; k++) begin
            is_err = (pc == 0) || (pc > 1 && pm[k] == 0);
            if (clr_count) m_cnt[k] = 0;
            else if (en && is_err && m_cnt[k] < (1 << cw[k]) - 1) m_cnt[k]++;
            if (en) begin
                m_none[k]  = (pc == 0);
                m_multi[k] = (pc > 1);
                m_valid[k] = !is_err;
                m_out[k]   = is_err ? 0 : hi;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s.d%0d.out", tag, k),   int'(out_w[k]),   m_out[k]);
            check($sformatf("%s.d%0d.valid", tag, k), int'(valid_w[k]), m_valid[k]);
            check($sformatf("%s.d%0d.none", tag, k),  int'(none_w[k]),  m_none[k]);
            check($sformatf("%s.d%0d.multi", tag, k), int'(multi_w[k]), m_multi[k]);
            check($sformatf("%s.d%0d.cnt", tag, k),   cnt_of(k),        m_cnt[k]);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        tbl[0]  = '{8'h01, 0, 1, 0, 0};
        tbl[1]  = '{8'h02, 1, 1, 0, 0};
        tbl[2]  = '{8'h04, 2, 1, 0, 0};
        tbl[3]  = '{8'h08, 3, 1, 0, 0};
        tbl[4]  = '{8'h10, 4, 1, 0, 0};
        tbl[5]  = '{8'h20, 5, 1, 0, 0};
        tbl[6]  = '{8'h40, 6, 1, 0, 0};
        tbl[7]  = '{8'h80, 7, 1, 0, 0};
        tbl[8]  = '{8'h00, 0, 0, 1, 0};
        tbl[9]  = '{8'h12, 0, 0, 0, 1};
        tbl[10] = '{8'hFF, 0, 0, 0, 1};

        rst = 1'b1; en = 1'b0; in_s = 8'h00; clr_count = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Walking one and error patterns on the strict variant, one cycle latency.
        en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_s = tbl[i].vin;
            step();
            check($sformatf("tbl%0d.out", i),   int'(out_w[0]),   tbl[i].exp_out);
            check($sformatf("tbl%0d.valid", i), int'(valid_w[0]), tbl[i].exp_valid);
            check($sformatf("tbl%0d.none", i),  int'(none_w[0]),  tbl[i].exp_none);
            check($sformatf("tbl%0d.multi", i), int'(multi_w[0]), tbl[i].exp_multi);
            check_all($sformatf("tbl%0d", i));
        end
        check("tbl.cnt0", int'(cnt0_w), 3);

        // Multi-hot 8'h12 in both modes after a clear.
        clr_count = 1'b1; en = 1'b0;
        step();
        check("clr.cnt0", int'(cnt0_w), 0);
        clr_count = 1'b0; en = 1'b1; in_s = 8'h12;
        step();
        check("mh.d0.out", int'(out_w[0]), 0);
        check("mh.d0.valid", int'(valid_w[0]), 0);
        check("mh.d0.cnt", int'(cnt0_w), 1);
        check("mh.d1.out", int'(out_w[1]), 4);
        check("mh.d1.valid", int'(valid_w[1]), 1);
        check("mh.d1.multi", int'(multi_w[1]), 1);
        check("mh.d1.cnt", int'(cnt1_w), 0);
        check_all("mh");

        // Enable hold.
        in_s = 8'h20;
        step();
        en = 1'b0; in_s = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold%0d.out", i), int'(out_w[0]), 5);
            check($sformatf("hold%0d.valid", i), int'(valid_w[0]), 1);
            check_all($sformatf("hold%0d", i));
        end

        // 2-bit counter saturation, then clear beating a same-cycle error.
        clr_count = 1'b1;
        step();
        clr_count = 1'b0; en = 1'b1; in_s = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("sat%0d.cnt2", i), int'(cnt2_w), (i < 3) ? i + 1 : 3);
        end
        check("sat.cnt0", int'(cnt0_w), 5);
        clr_count = 1'b1;
        step();
        check("clrwin.cnt2", int'(cnt2_w), 0);
        check("clrwin.cnt0", int'(cnt0_w), 0);
        check_all("clrwin");

        // Asynchronous reset mid-cycle with err_count at 5.
        clr_count = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre_rst.cnt0", int'(cnt0_w), 5);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst.out", int'(out_w[0]), 0);
        check("arst.none", int'(none_w[0]), 0);
        check("arst.cnt0", int'(cnt0_w), 0);
        check_all("arst");
        #1;
        rst = 1'b0;

        // Randomised traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       in_s = 8'h00;
                1:       in_s = 8'h01 << $urandom_range(0, 7);
                default: in_s = 8'($urandom);
            endcase
            en        = ($urandom_range(0, 4) != 0);
            clr_count = ($urandom_range(0, 19) == 0);
            step();
            check_all($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_encoder_8x3
